// File: rtl/fft_reorder_buf_if.sv
// Stream bundle for fft_reorder_buf: strobe-only sample input, valid/ready output,
// sticky status flags and a debug view of the write FSM.
interface fft_reorder_buf_if #(
  parameter int LGSIZE = 8,
  parameter int WIDTH  = 15
);
  // Input side has no backpressure: a sample is taken on every clock with i_ce high.
  // Output side: a sample transfers on a rising edge where o_valid && i_ready; while
  // o_valid && !i_ready, o_data/o_bin/o_last hold and o_valid stays high.
  logic                  i_ce;
  logic                  i_sync;
  logic [2*WIDTH-1:0]    i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [2*WIDTH-1:0]    o_data;
  logic [LGSIZE-1:0]     o_bin;
  logic                  o_last;
  logic                  o_overflow;
  logic                  o_sync_err;
  logic [1:0]            wr_state;

  modport master (
    output i_ce, i_sync, i_data, i_ready,
    input  o_valid, o_data, o_bin, o_last, o_overflow, o_sync_err, wr_state
  );

  modport slave (
    input  i_ce, i_sync, i_data, i_ready,
    output o_valid, o_data, o_bin, o_last, o_overflow, o_sync_err, wr_state
  );
endinterface

// File: rtl/fft_reorder_buf.sv
// Ping-pong bit-reversal reorder buffer with valid/ready output and sticky error flags.
// Optional macro FFT_REORDER_FFTSHIFT_EN: emit DC-centred order (bin N/2 first).
module fft_reorder_buf #(
  parameter int LGSIZE = 8,
  parameter int WIDTH  = 15
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fft_reorder_buf_if.slave bus
);
  localparam int N  = 1 << LGSIZE;
  localparam int DW = 2 * WIDTH;
  localparam logic [LGSIZE-1:0] LAST_IDX = {LGSIZE{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
    logic [LGSIZE-1:0] r;
    for (int b = 0; b < LGSIZE; b++) r[b] = v[LGSIZE-1-b];
    return r;
  endfunction

  // Bank select is the top address bit: bank A = 0, bank B = 1.
  logic [DW-1:0] mem [0:2*N-1];

  logic [1:0]        state, state_n;
  logic              wbank, wbank_n;
  logic [LGSIZE-1:0] wcnt, wcnt_n, waddr;
  logic              we, start;
  logic [1:0]        full, set_full, clr_full;
  logic              overflow, sync_err, ovf_set, serr_set;
  logic              target_free;

  logic              rbank, cbank, drained;
  logic [LGSIZE-1:0] rcnt, rd_idx;
  logic              issue, issue_last, pop, last_pop;
  logic [1:0]        occ;

  logic              rd_valid, rd_last;
  logic [DW-1:0]     rd_data;
  logic [LGSIZE-1:0] rd_bin;
  logic              out_valid, out_last;
  logic [DW-1:0]     out_data;
  logic [LGSIZE-1:0] out_bin;
  logic              skid_valid, skid_last;
  logic [DW-1:0]     skid_data;
  logic [LGSIZE-1:0] skid_bin;

  // A bank may be refilled once every read of it has been issued into the output
  // pipeline; the full flag itself drops with the frame's last output transfer.
  assign target_free = !full[wbank] || (drained && (cbank == wbank));

  always_comb begin
    state_n  = state;
    wbank_n  = wbank;
    wcnt_n   = wcnt;
    waddr    = wcnt;
    we       = 1'b0;
    start    = 1'b0;
    set_full = 2'b00;
    ovf_set  = 1'b0;
    serr_set = 1'b0;
    if (bus.i_ce) begin
      case (state)
        S_FILL: begin
          if (bus.i_sync && (wcnt != '0)) begin
            serr_set = 1'b1;
            we       = 1'b1;
            waddr    = '0;
            wcnt_n   = LGSIZE'(1);
          end else begin
            we = 1'b1;
            if (wcnt == LAST_IDX) begin
              set_full[wbank] = 1'b1;
              wbank_n         = ~wbank;
              wcnt_n          = '0;
              state_n         = S_IDLE;
            end else begin
              wcnt_n = wcnt + LGSIZE'(1);
            end
          end
        end
        S_DROP: begin
          if (bus.i_sync && (wcnt != '0)) begin
            serr_set = 1'b1;
            start    = 1'b1;
          end else if (wcnt == LAST_IDX) begin
            wcnt_n  = '0;
            state_n = S_IDLE;
          end else begin
            wcnt_n = wcnt + LGSIZE'(1);
          end
        end
        default: start = bus.i_sync;
      endcase
    end
    // Start of a frame, either from IDLE or re-evaluated on a sync that cut a drop short.
    if (start) begin
      wcnt_n = LGSIZE'(1);
      if (target_free) begin
        state_n = S_FILL;
        we      = 1'b1;
        waddr   = '0;
      end else begin
        state_n = S_DROP;
        ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      wbank    <= 1'b0;
      wcnt     <= '0;
      full     <= 2'b00;
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      wbank    <= wbank_n;
      wcnt     <= wcnt_n;
      full     <= (full & ~clr_full) | set_full;
      overflow <= overflow | ovf_set;
      sync_err <= sync_err | serr_set;
    end
  end

`ifdef FFT_REORDER_FFTSHIFT_EN
  assign rd_idx = rcnt ^ {1'b1, {(LGSIZE-1){1'b0}}};
`else
  assign rd_idx = rcnt;
`endif

  // Up to two samples may sit in out/skid plus one in the RAM read register.
  assign occ        = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_valid};
  assign pop        = out_valid && bus.i_ready;
  assign last_pop   = pop && out_last;
  assign issue      = full[rbank] && ((occ - {1'b0, pop}) < 2'd2);
  assign issue_last = issue && (rcnt == LAST_IDX);
  assign clr_full   = last_pop ? (2'b01 << cbank) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (we) mem[{wbank, waddr}] <= bus.i_data;
    if (issue) rd_data <= mem[{rbank, bitrev(rd_idx)}];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rbank    <= 1'b0;
      cbank    <= 1'b0;
      drained  <= 1'b0;
      rcnt     <= '0;
      rd_valid <= 1'b0;
      rd_bin   <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rcnt    <= rcnt + LGSIZE'(1);
        rd_bin  <= rd_idx;
        rd_last <= (rcnt == LAST_IDX);
      end
      if (issue_last) rbank <= ~rbank;
      if (last_pop) begin
        cbank   <= ~cbank;
        drained <= 1'b0;
      end
      if (issue_last) drained <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bin    <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_bin   <= '0;
      skid_last  <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_bin    <= skid_bin;
        out_last   <= skid_last;
        skid_valid <= rd_valid;
        skid_data  <= rd_data;
        skid_bin   <= rd_bin;
        skid_last  <= rd_valid && rd_last;
      end else begin
        out_valid  <= rd_valid;
        out_data   <= rd_data;
        out_bin    <= rd_bin;
        out_last   <= rd_valid && rd_last;
      end
    end else if (rd_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= rd_data;
      skid_bin   <= rd_bin;
      skid_last  <= rd_last;
    end
  end

  assign bus.o_valid    = out_valid;
  assign bus.o_data     = out_data;
  assign bus.o_bin      = out_bin;
  assign bus.o_last     = out_last;
  assign bus.o_overflow = overflow;
  assign bus.o_sync_err = sync_err;
  assign bus.wr_state   = state;
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Bench for fft_reorder_buf at LGSIZE=3, WIDTH=4: table-driven first frame, directed
// corner sequences, and randomized frames scored against a frame-level reference model.
module tb_fft_reorder_buf;
  localparam int LG = 3;
  localparam int WD = 4;
  localparam int N  = 1 << LG;
  localparam int DW = 2 * WD;
  localparam int EW = DW + LG + 1;
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SHIFT = N / 2;
`else
  localparam int SHIFT = 0;
`endif

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_data;
    logic [LG-1:0] exp_bin;
    logic          exp_last;
  } vec_t;

  logic clk;
  logic rst;
  fft_reorder_buf_if #(.LGSIZE(LG), .WIDTH(WD)) bus();
  fft_reorder_buf #(.LGSIZE(LG), .WIDTH(WD)) dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] cur_frame [N];
  vec_t vec [N];
  int tab_data [N];
  int tab_bin [N];
  int frames_done = 0;
  int lasts_seen = 0;
  bit sb_en = 0;
  bit gap_mon = 0;
  bit seen_valid = 0;
  int gap_cnt = 0;
  int ready_mode = 0;
  int pc = 0;

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready driver: 0 = always, 1 = never, 2 = 1,0,0,1 pattern, 3 = random 75%
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.i_ready = 1'b1;
      1: bus.i_ready = 1'b0;
      2: bus.i_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
      default: bus.i_ready = ($urandom_range(0, 3) != 0);
    endcase
    pc++;
  end

  function automatic int rev(input int v);
    int r = 0;
    for (int b = 0; b < LG; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  // reference model: a complete frame yields sample[bitrev(j ^ SHIFT)] tagged bin j ^ SHIFT
  task automatic push_frame();
    for (int j = 0; j < N; j++) begin
      int idx = j ^ SHIFT;
      exp_q.push_back({cur_frame[rev(idx)], LG'(idx), (j == N - 1)});
    end
    frames_done++;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic s);
    bus.i_ce   = 1'b1;
    bus.i_sync = s;
    bus.i_data = d;
    step();
    bus.i_ce   = 1'b0;
    bus.i_sync = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int k = 0; k < N; k++) begin
      cur_frame[k] = DW'($urandom);
      send_sample(cur_frame[k], k == 0);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
    end
    push_frame();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
    repeat (4) step();
    check({name, "_idle"}, 32'(bus.o_valid), 0);
  endtask

  // scoreboard: every valid output must match the head of the expected queue
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (sb_en && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%0h bin %0d, expected nothing", bus.o_data, bus.o_bin);
      end else begin
        e = exp_q[0];
        check("o_data", 32'(bus.o_data), 32'(e[EW-1 -: DW]));
        check("o_bin", 32'(bus.o_bin), 32'(e[LG:1]));
        check("o_last", 32'(bus.o_last), 32'(e[0]));
        if (bus.i_ready) begin
          void'(exp_q.pop_front());
          if (e[0]) lasts_seen++;
        end
      end
    end
    if (!gap_mon) seen_valid = 0;
    else if (bus.o_valid) seen_valid = 1;
    else if (seen_valid && exp_q.size() != 0) gap_cnt++;
  end

  initial begin
    int l0;
    int n;
    rst = 1'b1;
    bus.i_ce = 1'b0;
    bus.i_sync = 1'b0;
    bus.i_data = '0;
`ifdef FFT_REORDER_FFTSHIFT_EN
    tab_data = '{1, 5, 3, 7, 0, 4, 2, 6};
    tab_bin  = '{4, 5, 6, 7, 0, 1, 2, 3};
`else
    tab_data = '{0, 4, 2, 6, 1, 5, 3, 7};
    tab_bin  = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    for (int k = 0; k < N; k++) begin
      vec[k].din      = DW'(k);
      vec[k].exp_data = DW'(tab_data[k]);
      vec[k].exp_bin  = LG'(tab_bin[k]);
      vec[k].exp_last = (k == N - 1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_last", 32'(bus.o_last), 0);
    check("rst_bin", 32'(bus.o_bin), 0);
    check("rst_overflow", 32'(bus.o_overflow), 0);
    check("rst_sync_err", 32'(bus.o_sync_err), 0);
    check("rst_state", 32'(bus.wr_state), 0);
    rst = 1'b0;
    step();
    step();

    // single frame, positions 0..N-1, checked against the table
    for (int k = 0; k < N; k++) send_sample(vec[k].din, k == 0);
    check("s1_valid_t0", 32'(bus.o_valid), 0);
    step();
    check("s1_valid_t1", 32'(bus.o_valid), 0);
    step();
    check("s1_valid_t2", 32'(bus.o_valid), 1);
    for (int j = 0; j < N; j++) begin
      check("s1_data", 32'(bus.o_data), 32'(vec[j].exp_data));
      check("s1_bin", 32'(bus.o_bin), 32'(vec[j].exp_bin));
      check("s1_last", 32'(bus.o_last), 32'(vec[j].exp_last));
      step();
    end
    check("s1_valid_end", 32'(bus.o_valid), 0);

    // 20 back-to-back frames at full rate
    sb_en = 1;
    gap_mon = 1;
    for (int f = 0; f < 20; f++) send_frame(0);
    wait_drain("s2_drain");
    gap_mon = 0;
    check("s2_gaps", 32'(gap_cnt), 0);
    check("s2_overflow", 32'(bus.o_overflow), 0);

    // three frames with the sink stalled: third is dropped
    ready_mode = 1;
    step();
    step();
    send_frame(0);
    send_frame(0);
    check("s3_ovf_before", 32'(bus.o_overflow), 0);
    send_sample(8'h55, 1'b1);
    check("s3_ovf_after", 32'(bus.o_overflow), 1);
    check("s3_state_drop", 32'(bus.wr_state), 2);
    for (int k = 1; k < N; k++) send_sample(DW'(8'h60 + k), 1'b0);
    check("s3_state_idle", 32'(bus.wr_state), 0);
    ready_mode = 0;
    wait_drain("s3_drain");

    // ready toggling 1,0,0,1
    l0 = lasts_seen;
    ready_mode = 2;
    send_frame(0);
    send_frame(0);
    wait_drain("s4_drain");
    ready_mode = 0;
    check("s4_frames", 32'(lasts_seen - l0), 2);

    // sync reasserted at wcnt=5, then a full frame
    for (int k = 0; k < 5; k++) send_sample(DW'(8'hA0 + k), k == 0);
    check("s5_serr_before", 32'(bus.o_sync_err), 0);
    cur_frame[0] = DW'($urandom);
    send_sample(cur_frame[0], 1'b1);
    check("s5_serr_after", 32'(bus.o_sync_err), 1);
    check("s5_state_fill", 32'(bus.wr_state), 1);
    for (int k = 1; k < N; k++) begin
      cur_frame[k] = DW'($urandom);
      send_sample(cur_frame[k], 1'b0);
    end
    push_frame();
    wait_drain("s5_drain");

    // asynchronous reset in the middle of a drain
    send_frame(0);
    n = 0;
    while (exp_q.size() > N - 3 && n < 50) begin
      step();
      n++;
    end
    check("s6_valid_pre", 32'(bus.o_valid), 1);
    check("s6_ovf_pre", 32'(bus.o_overflow), 1);
    check("s6_serr_pre", 32'(bus.o_sync_err), 1);
    sb_en = 0;
    #2 rst = 1'b1;
    #1;
    check("s6_valid_rst", 32'(bus.o_valid), 0);
    check("s6_ovf_rst", 32'(bus.o_overflow), 0);
    check("s6_serr_rst", 32'(bus.o_sync_err), 0);
    exp_q.delete();
    frames_done = lasts_seen;
    step();
    step();
    rst = 1'b0;
    step();
    sb_en = 1;
    send_frame(0);
    wait_drain("s6_drain");

    // random frames, gaps and backpressure, throttled so no frame is ever dropped
    ready_mode = 3;
    for (int f = 0; f < 12; f++) begin
      n = 0;
      while ((frames_done - lasts_seen) > 1 && n < 2000) begin
        step();
        n++;
      end
      check("s7_throttle", 32'(n < 2000), 1);
      send_frame(2);
    end
    wait_drain("s7_drain");
    ready_mode = 0;
    check("s7_overflow", 32'(bus.o_overflow), 0);
    check("s7_sync_err", 32'(bus.o_sync_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
